config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024: total scan-chain length in bits, at least 1.
REQ-002 SHALL have parameter WORD_W, default 32: width of a configuration word.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 SHALL have port cfg_data, input, WORD_W bits: configuration or checksum word.
REQ-007 SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the block accepts cfg_data this cycle.
REQ-009 SHALL have port prog_out, output, 1 bit: serial bit driven to the row's first prog_in.
REQ-010 SHALL have port prog_en, output, 1 bit: chain shift enable; prog_out is meaningful only when it is 1.
REQ-011 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-012 SHALL have port done, output, 1 bit: the load completed and the checksum matched.
REQ-013 SHALL have port err, output, 1 bit: the load completed and the checksum mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, CHECK, DONE and ERR.
REQ-015 SHALL treat a word as transferred only in a cycle where cfg_valid=1 and cfg_ready=1.
REQ-016 IDLE: start=1 SHALL move to SHIFT; cfg_ready=0; prog_en=0.
REQ-017 SHIFT: SHALL hold one shift register and one holding buffer; cfg_ready=1 while the buffer is empty and words remain to be accepted.
REQ-018 SHIFT: data words needed = ceil(CHAIN_LEN/WORD_W); after the last data word, cfg_ready SHALL stay 0 until CHECK.
REQ-019 SHIFT: each cycle the shift register holds a bit, the block SHALL drive prog_en=1 and prog_out = the current MSB, shifting MSB-first.
REQ-020 SHIFT: when the shift register is empty, it SHALL reload from the buffer in the same cycle; if the buffer is also empty, prog_en=0 for that cycle (stall; the chain holds).
REQ-021 Latency: a word accepted in cycle N into an idle path SHALL have its MSB on prog_out with prog_en=1 in cycle N+1; a continuous stream SHALL produce no prog_en gaps.
REQ-022 SHALL assert prog_en for exactly CHAIN_LEN cycles per load.
REQ-023 Low-order bits of the final word beyond CHAIN_LEN SHALL be discarded and never driven.
REQ-024 SHALL enter CHECK the cycle after the CHAIN_LEN-th bit.
REQ-025 SHALL keep a running checksum: the XOR of all accepted data words, cleared on start.
REQ-026 CHECK: cfg_ready=1; prog_en=0.
REQ-027 CHECK: the accepted word SHALL be compared with the checksum, going to DONE on equality and ERR otherwise.
REQ-028 DONE/ERR: done or err respectively SHALL be held at 1; start=1 SHALL begin a new load, clearing done/err the next cycle.
REQ-029 busy SHALL be 1 in SHIFT and CHECK only.
REQ-030 start during SHIFT or CHECK SHALL be ignored.
REQ-031 cfg_valid with cfg_ready=0 SHALL be ignored and the data not consumed.
REQ-032 The bit counter SHALL be clog2(CHAIN_LEN+1) bits wide and SHALL not wrap.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, empty the buffer and shift register, and zero the counters and checksum.
REQ-034 rst=0 SHALL immediately drive cfg_ready, prog_en, prog_out, busy, done and err to 0.
REQ-035 Reset mid-load SHALL abandon the load with no further prog_en pulses; recovery requires a fresh start.

Structure
REQ-036 Package config_pkg SHALL hold the FSM state enum, the default WORD_W, and the checksum width constant.
REQ-037 The shift register plus holding buffer SHALL be a sub-module, cfg_shifter, with a word-load/bit-pop interface; the FSM, counters and checksum SHALL reside in config_loader.

Verification
REQ-038 CHAIN_LEN=64, words 0xA5A5A5A5 and 0x0F0F0F0F, then checksum 0xAAAAAAAA, valid held high -> 64 contiguous prog_en cycles, bits MSB-first, done=1.
REQ-039 Same stimulus with checksum 0x00000000 -> 64 prog_en cycles, err=1, done=0.
REQ-040 CHAIN_LEN=40, words 0xFFFFFFFF and 0x80000000 -> exactly 40 prog_en cycles, the final 8 bits being 1,0,0,0,0,0,0,0.
REQ-041 CHAIN_LEN=64, cfg_valid deasserted 5 cycles after the first word -> prog_en=0 for the gap, total prog_en count still 64.
REQ-042 rst=0 asserted after 20 shifted bits -> prog_en=0 and busy=0 immediately; a later start plus a full stream -> done=1 with a correct 64-bit sequence.
REQ-043 start pulsed during SHIFT -> no state change; cfg_valid in IDLE -> cfg_ready=0 and no bits shifted.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: shared FSM state type, default word width and checksum width for the config loader.
package config_pkg;
  localparam int DEF_WORD_W = 32;
  localparam int CSUM_W = DEF_WORD_W;
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_CHECK, ST_DONE, ST_ERR} state_e;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/cfg_shifter.sv
// cfg_shifter: one-word MSB-first shift register backed by a single holding buffer.
module cfg_shifter
  import config_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              pop_i,
  output logic              buf_full_o,
  output logic              bit_valid_o,
  output logic              bit_o
);
  localparam int CW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] sr_q, sr_d, buf_q, buf_d;
  logic [CW-1:0]     cnt_q, cnt_d, left;
  logic              full_q, full_d;
  assign bit_o       = sr_q[WORD_W-1];
  assign bit_valid_o = cnt_q != '0;
  assign buf_full_o  = full_q;
  // An emptying shift register refills in the same cycle, from the buffer first.
  always_comb begin
    left   = cnt_q - CW'(pop_i && cnt_q != '0);
    sr_d   = (pop_i && left != '0) ? sr_q << 1 : sr_q;
    cnt_d  = left;
    buf_d  = buf_q;
    full_d = full_q;
    if (flush_i) begin
      sr_d   = '0;
      cnt_d  = '0;
      buf_d  = '0;
      full_d = 1'b0;
    end else if (left == '0 && full_q) begin
      sr_d   = buf_q;
      cnt_d  = CW'(WORD_W);
      full_d = 1'b0;
    end else if (left == '0 && load_i) begin
      sr_d  = word_i;
      cnt_d = CW'(WORD_W);
    end else if (load_i) begin
      buf_d  = word_i;
      full_d = 1'b1;
    end
  end
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end
endmodule

// File: rtl/config_loader.sv
// config_loader: streams configuration words serially into a scan chain and verifies a trailing XOR checksum.
module config_loader
  import config_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_out,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int N_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(N_WORDS + 1);
  state_e            state_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [NW-1:0]     word_cnt_q;
  logic [WORD_W-1:0] csum_q;
  logic              busy_q, done_q, err_q;
  logic              buf_full, bit_valid, bit_msb, load, last_bit;
  assign cfg_ready = (state_q == ST_SHIFT && !buf_full && word_cnt_q < NW'(N_WORDS)) ||
                     state_q == ST_CHECK;
  assign load      = cfg_valid && cfg_ready && state_q == ST_SHIFT;
  assign prog_en   = state_q == ST_SHIFT && bit_valid;
  assign prog_out  = prog_en && bit_msb;
  assign last_bit  = prog_en && bit_cnt_q == BW'(CHAIN_LEN - 1);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  // Flushing on the last chain bit drops the unused low bits of the final word.
  cfg_shifter #(.WORD_W(WORD_W)) u_shifter (
    .prog_clk   (prog_clk),
    .rst        (rst),
    .flush_i    (last_bit),
    .load_i     (load),
    .word_i     (cfg_data),
    .pop_i      (prog_en),
    .buf_full_o (buf_full),
    .bit_valid_o(bit_valid),
    .bit_o      (bit_msb)
  );
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: if (start) begin
          state_q    <= ST_SHIFT;
          bit_cnt_q  <= '0;
          word_cnt_q <= '0;
          csum_q     <= '0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
        end
        ST_SHIFT: begin
          if (load) begin
            csum_q     <= csum_q ^ cfg_data;
            word_cnt_q <= word_cnt_q + NW'(1);
          end
          if (prog_en) bit_cnt_q <= bit_cnt_q + BW'(1);
          if (last_bit) state_q <= ST_CHECK;
        end
        ST_CHECK: if (cfg_valid) begin
          state_q <= (cfg_data == csum_q) ? ST_DONE : ST_ERR;
          busy_q  <= 1'b0;
          done_q  <= cfg_data == csum_q;
          err_q   <= cfg_data != csum_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
